// File: rtl/multiexp_pnt_scl_feeder_if.sv
// Generic AXI-stream style bundle used between the feeder and the multiexp top.
// sop/eop frame a packet, ctl/err/mod are side-band fields.
interface if_axi_stream #(
    parameter int unsigned DAT_BITS = 381,
    parameter int unsigned CTL_BITS = 8,
    parameter int unsigned MOD_BITS = 6
);
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic                err;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;
    logic [MOD_BITS-1:0] mod;

    modport source (output val, dat, sop, eop, err, ctl, mod, input rdy);
    modport sink   (input val, dat, sop, eop, err, ctl, mod, output rdy);
endinterface

// File: rtl/multiexp_pnt_scl_feeder.sv
// Replays an element list (scalar + point words) from memory NUM_PASSES times into the
// multiexp stream. Define MULTIEXP_FEEDER_STATS_EN to add the o_stall_cnt output.
module multiexp_pnt_scl_feeder #(
    parameter int unsigned DAT_BITS       = 381,
    parameter int unsigned WORDS_PER_ELEM = 7,
    parameter int unsigned NUM_PASSES     = DAT_BITS,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned ADDR_BITS      = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [63:0]          i_num_in,
    input  logic [ADDR_BITS-1:0] i_base_addr,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_rd_req_val,
    input  logic                 i_rd_req_rdy,
    output logic [ADDR_BITS-1:0] o_rd_addr,
    input  logic                 i_rd_dat_val,
    input  logic [DAT_BITS-1:0]  i_rd_dat,
`ifdef MULTIEXP_FEEDER_STATS_EN
    output logic [31:0]          o_stall_cnt,
`endif
    if_axi_stream.source         o_pnt_scl_if
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WORD_W = (WORDS_PER_ELEM > 1) ? $clog2(WORDS_PER_ELEM) : 1;
    localparam int unsigned PASS_W = $clog2(NUM_PASSES + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [63:0]          num_q;
    logic [ADDR_BITS-1:0] base_q;
    logic [ADDR_BITS-1:0] rd_addr_q;
    logic [WORD_W-1:0]    word_q;
    logic [63:0]          elem_q;
    logic [PASS_W-1:0]    pass_q;
    logic [CNT_W-1:0]     outst_q;
    logic [CNT_W-1:0]     fifo_cnt_q;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [DAT_BITS-1:0]  fifo_mem [FIFO_DEPTH];
    logic [WORD_W-1:0]    out_word_q;
    logic                 done_q;

    logic                 start_ok, start_zero;
    logic                 req_acc, push, pop;
    logic                 last_word, last_elem, last_pass, drain_end;
    logic [CNT_W:0]       occupancy;

    assign start_ok   = (state_q == IDLE) && i_start && (i_num_in != 64'd0);
    assign start_zero = (state_q == IDLE) && i_start && (i_num_in == 64'd0);
    assign last_word  = (word_q == WORD_W'(WORDS_PER_ELEM - 1));
    assign last_elem  = (elem_q == num_q - 64'd1);
    assign last_pass  = (pass_q == PASS_W'(NUM_PASSES - 1));

    // Every issued request owns a FIFO slot until its word leaves, so responses never overflow.
    assign occupancy    = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
    assign o_rd_req_val = (state_q == FETCH) && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign o_rd_addr    = rd_addr_q;
    assign req_acc      = o_rd_req_val && i_rd_req_rdy;

    assign push = i_rd_dat_val && (state_q != IDLE);
    assign pop  = o_pnt_scl_if.val && o_pnt_scl_if.rdy;

    assign o_pnt_scl_if.val = (fifo_cnt_q != '0);
    assign o_pnt_scl_if.dat = fifo_mem[rd_ptr_q];
    assign o_pnt_scl_if.sop = o_pnt_scl_if.val && (out_word_q == '0);
    assign o_pnt_scl_if.eop = o_pnt_scl_if.val && (out_word_q == WORD_W'(WORDS_PER_ELEM - 1));
    assign o_pnt_scl_if.err = 1'b0;
    assign o_pnt_scl_if.ctl = '0;
    assign o_pnt_scl_if.mod = '0;

    assign o_busy = (state_q != IDLE);
    assign o_done = done_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = FETCH;
            FETCH:   if (req_acc && last_word && last_elem && last_pass) state_d = DRAIN;
            // No request left in flight and the final buffered word is leaving: job complete.
            DRAIN:   if (pop && !push && (outst_q == '0) && (fifo_cnt_q == CNT_W'(1))) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign drain_end = (state_q == DRAIN) && (state_d == IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= start_zero || drain_end;
        end
    end

    // Elements are contiguous, so the address just steps by one and rewinds on the list wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            num_q     <= '0;
            base_q    <= '0;
            rd_addr_q <= '0;
            word_q    <= '0;
            elem_q    <= '0;
            pass_q    <= '0;
        end else if (start_ok) begin
            num_q     <= i_num_in;
            base_q    <= i_base_addr;
            rd_addr_q <= i_base_addr;
            word_q    <= '0;
            elem_q    <= '0;
            pass_q    <= '0;
        end else if (req_acc) begin
            if (last_word) begin
                word_q <= '0;
                if (last_elem) begin
                    elem_q    <= '0;
                    pass_q    <= pass_q + PASS_W'(1);
                    rd_addr_q <= base_q;
                end else begin
                    elem_q    <= elem_q + 64'd1;
                    rd_addr_q <= rd_addr_q + ADDR_BITS'(1);
                end
            end else begin
                word_q    <= word_q + WORD_W'(1);
                rd_addr_q <= rd_addr_q + ADDR_BITS'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            outst_q <= '0;
        end else begin
            case ({req_acc, push})
                2'b10:   outst_q <= outst_q + CNT_W'(1);
                2'b01:   outst_q <= outst_q - CNT_W'(1);
                default: outst_q <= outst_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wr_ptr_q] <= i_rd_dat;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            out_word_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
            if (start_ok) begin
                out_word_q <= '0;
            end else if (pop) begin
                out_word_q <= (out_word_q == WORD_W'(WORDS_PER_ELEM - 1)) ? '0
                                                                         : out_word_q + WORD_W'(1);
            end
        end
    end

`ifdef MULTIEXP_FEEDER_STATS_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
        end else if (start_ok) begin
            stall_cnt_q <= '0;
        end else if (o_pnt_scl_if.val && !o_pnt_scl_if.rdy && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/multiexp_pnt_scl_feeder.md
MULTIEXP_PNT_SCL_FEEDER -- requirements
Module: multiexp_pnt_scl_feeder

Interface
REQ-001 Parameter DAT_BITS, default 381: word width; equals the downstream multiexp scalar width.
REQ-002 Parameter WORDS_PER_ELEM, default 7: words per element (1 scalar + 6 Fp2 point coordinates).
REQ-003 Parameter NUM_PASSES, default DAT_BITS: number of times the full element list is replayed (one pass per scalar bit).
REQ-004 Parameter FIFO_DEPTH, default 16: response buffer depth in words, power of 2, at least 4.
REQ-005 Parameter ADDR_BITS, default 32: word address width.
REQ-006 i_clk  in  1  sole clock; all logic on its rising edge.
REQ-007 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-008 i_start  in  1  single-cycle job start pulse.
REQ-009 i_num_in  in  64  element count for the job.
REQ-010 i_base_addr  in  ADDR_BITS  word address of element 0, word 0.
REQ-011 o_busy  out  1  high from the accepted start until the done pulse.
REQ-012 o_done  out  1  single-cycle pulse at job end.
REQ-013 o_rd_req_val / i_rd_req_rdy / o_rd_addr  out/in/out  1/1/ADDR_BITS  memory read request handshake.
REQ-014 i_rd_dat_val / i_rd_dat  in/in  1/DAT_BITS  in-order read response, no backpressure.
REQ-015 o_pnt_scl_if  if_axi_stream.source  DAT_BITS  element stream to the multiexp top; sop marks the scalar word, eop marks the last point word; ctl, err and mod are 0.

Function
REQ-016 States SHALL be IDLE, FETCH and DRAIN.
REQ-017 IDLE->FETCH SHALL occur on i_start when i_num_in!=0; i_num_in and i_base_addr SHALL be latched at that edge.
REQ-018 i_start with i_num_in==0 SHALL pulse o_done on the next cycle and remain in IDLE.
REQ-019 i_start outside IDLE SHALL be ignored.
REQ-020 In FETCH, o_rd_addr SHALL equal base + elem*WORDS_PER_ELEM + word; word wraps at WORDS_PER_ELEM, elem wraps at num_in, and pass increments on the elem wrap.
REQ-021 Address arithmetic SHALL be modulo 2^ADDR_BITS.
REQ-022 A request SHALL be issued only while outstanding + fifo_count < FIFO_DEPTH, so responses never overflow the FIFO.
REQ-023 The outstanding count SHALL increment on request accept, decrement on response, and hold on a simultaneous accept and response.
REQ-024 A request held by i_rd_req_rdy=0 SHALL keep o_rd_addr stable.
REQ-025 After the last request of pass NUM_PASSES-1 is accepted, FETCH->DRAIN.
REQ-026 DRAIN->IDLE SHALL occur when the last eop word is accepted downstream; o_done SHALL pulse one cycle and o_busy SHALL fall in the same cycle.
REQ-027 Output val SHALL assert no earlier than one cycle after the corresponding i_rd_dat_val; words SHALL leave in response order.
REQ-028 Output handshake: a word transfers on val&&rdy; val and dat SHALL be held while rdy=0.
REQ-029 Simultaneous FIFO push and pop SHALL leave fifo_count unchanged; a full FIFO with pop and push in the same cycle SHALL be legal.
REQ-030 The output SHALL carry exactly num_in*NUM_PASSES*WORDS_PER_ELEM words per job.

Reset
REQ-031 Reset SHALL apply asynchronously on i_rst_n low and release synchronously to i_clk.
REQ-032 On reset: state=IDLE; o_busy=0; o_done=0; o_rd_req_val=0; o_pnt_scl_if.val=0, sop=0, eop=0; all counters, the outstanding count and FIFO pointers SHALL clear.
REQ-033 Reset mid-job SHALL abandon the job; responses arriving after release SHALL be dropped while in IDLE.

Configuration
REQ-034 Macro MULTIEXP_FEEDER_STATS_EN, when defined, SHALL add output o_stall_cnt (32 bits): cycles with o_pnt_scl_if.val&&!rdy, cleared on job start, saturating at 2^32-1.
REQ-035 Without MULTIEXP_FEEDER_STATS_EN, the o_stall_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-036 num_in=2, NUM_PASSES=2, base=0x100, 1-cycle memory, rdy=1 -> 28 words; addresses 0x100..0x10D twice; sop on words 0,7,14,21; one o_done.
REQ-037 num_in=0 start -> o_done pulse next cycle; no requests; o_busy stays 0.
REQ-038 Memory latency 20 cycles, FIFO_DEPTH=4 -> outstanding+fifo_count never exceeds 4; no data loss.
REQ-039 Downstream rdy random 30% -> output data and order match the reference model; dat held while stalled; o_stall_cnt equals the stall cycles when MULTIEXP_FEEDER_STATS_EN is defined.
REQ-040 base=0xFFFFFFFE, num_in=1 -> addresses wrap to 0x00000000..0x00000004.
REQ-041 i_rst_n low mid-FETCH with 3 requests outstanding -> outputs reset immediately; late responses ignored; a subsequent job completes correctly.
